// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: registered, parametrised ALU for the instruction-list core.
//
// One operation is accepted per start/ready handshake. Logic, compare,
// pass-through and add/sub operations finish in one cycle; MUL, DIV and MOD
// iterate for WIDTH cycles. Every completion raises done for one cycle with
// the result and flags already registered.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while ready=1
//   op_code    operation code (IWIDTH bits), latched on accept
//   in_a/in_b  signed operands (WIDTH bits), latched on accept
//   c_in/b_in  carry-in (ADD) / borrow-in (SUB), latched on accept
//   ready      block can accept start (IDLE or DONE)
//   done       one-cycle completion pulse
//   result     signed result, held until the next done
//   c_out      carry out (ADD only)
//   b_out      borrow out (SUB only)
//   ovf        signed overflow (ADD/SUB/MUL/DIV)
//   div_zero   divisor was zero (DIV/MOD)
//   flag_valid flags are meaningful (ADD/SUB/MUL/DIV/MOD)
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IWIDTH-1:0] op_code,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              c_in,
  input  logic              b_in,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              c_out,
  output logic              b_out,
  output logic              ovf,
  output logic              div_zero,
  output logic              flag_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [4:0] {
    K_AND  = 5'd0,  K_ANDN = 5'd1,  K_OR   = 5'd2,  K_ORN  = 5'd3,
    K_XOR  = 5'd4,  K_XORN = 5'd5,  K_NOT  = 5'd6,  K_ADD  = 5'd7,
    K_SUB  = 5'd8,  K_MUL  = 5'd9,  K_DIV  = 5'd10, K_MOD  = 5'd11,
    K_GT   = 5'd12, K_GE   = 5'd13, K_EQ   = 5'd14, K_NE   = 5'd15,
    K_LE   = 5'd16, K_LT   = 5'd17, K_SET  = 5'd18, K_RST  = 5'd19,
    K_PASS = 5'd20, K_PASSN = 5'd21
  } kind_e;

  // Map the external opcode onto an internal operation kind.
  function automatic kind_e decode(input logic [IWIDTH-1:0] op);
    kind_e k;
    case (op)
      IWIDTH'(8'h00): k = K_AND;
      IWIDTH'(8'h01): k = K_ANDN;
      IWIDTH'(8'h02): k = K_OR;
      IWIDTH'(8'h03): k = K_ORN;
      IWIDTH'(8'h04): k = K_XOR;
      IWIDTH'(8'h05): k = K_XORN;
      IWIDTH'(8'h06): k = K_NOT;
      IWIDTH'(8'h07): k = K_ADD;
      IWIDTH'(8'h08): k = K_SUB;
      IWIDTH'(8'h09): k = K_MUL;
      IWIDTH'(8'h0A): k = K_DIV;
      IWIDTH'(8'h0B): k = K_MOD;
      IWIDTH'(8'h0C): k = K_GT;
      IWIDTH'(8'h0D): k = K_GE;
      IWIDTH'(8'h0E): k = K_EQ;
      IWIDTH'(8'h0F): k = K_NE;
      IWIDTH'(8'h10): k = K_LE;
      IWIDTH'(8'h11): k = K_LT;
      IWIDTH'(8'h1B): k = K_SET;
      IWIDTH'(8'h1C): k = K_RST;
      IWIDTH'(8'h1D): k = K_PASS;
      IWIDTH'(8'h1E): k = K_PASSN;
      IWIDTH'(8'h1F): k = K_PASS;
      IWIDTH'(8'h20): k = K_PASSN;
      default:        k = K_PASS;
    endcase
    return k;
  endfunction

  // Unsigned magnitude of a two's complement value; MIN_V maps onto itself,
  // which is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // Two's complement negate helper.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // True when the top bits of an extended result are not a pure sign extension.
  function automatic logic top_not_sext(input logic [WIDTH+1:0] v);
    return (|v[WIDTH+1:WIDTH-1]) & ~(&v[WIDTH+1:WIDTH-1]);
  endfunction

  state_e state_q, state_d;
  kind_e  kind_s, kind_q;

  logic             ready_s, done_s, accept_s, iter_start_s, last_s;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;

  // multiply datapath
  logic [W2-1:0]    acc_q, mcand_q, addend_s, acc_nx_s;
  logic [WIDTH-1:0] mplier_q;

  // divide datapath
  logic [WIDTH:0]   rem_q, rem_sh_s, rem_nx_s;
  logic [WIDTH-1:0] quot_q, quot_nx_s, dvsr_q, quo_fin_s, rem_fin_s;
  logic             div_ge_s, neg_quo_q, neg_rem_q;

  // single-cycle results
  logic [WIDTH:0]   add_u_s, sub_u_s;
  logic [WIDTH+1:0] add_x_s, sub_x_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_cout_s, sc_bout_s, sc_ovf_s, sc_dz_s, sc_fv_s;

  // iterative completion results
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_ovf_s;

  // registered outputs
  logic [WIDTH-1:0] result_q;
  logic             c_out_q, b_out_q, ovf_q, div_zero_q, flag_valid_q;

  assign kind_s       = decode(op_code);
  assign accept_s     = start & ready_s;
  assign iter_start_s = (kind_s == K_MUL) |
                        (((kind_s == K_DIV) | (kind_s == K_MOD)) & (in_b != '0));
  assign last_s       = (cnt_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE behaves like IDLE for a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = iter_start_s ? S_ITER : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    ready_s = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE:  begin ready_s = 1'b1; done_s = 1'b0; end
      S_ITER:  begin ready_s = 1'b0; done_s = 1'b0; end
      S_DONE:  begin ready_s = 1'b1; done_s = 1'b1; end
      default: begin ready_s = 1'b1; done_s = 1'b0; end
    endcase
  end

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    add_u_s   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, c_in};
    sub_u_s   = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, b_in};
    add_x_s   = {{2{in_a[WIDTH-1]}}, in_a} + {{2{in_b[WIDTH-1]}}, in_b}
              + {{(WIDTH+1){1'b0}}, c_in};
    sub_x_s   = {{2{in_a[WIDTH-1]}}, in_a} - {{2{in_b[WIDTH-1]}}, in_b}
              - {{(WIDTH+1){1'b0}}, b_in};
    sc_res_s  = in_a;
    sc_cout_s = 1'b0;
    sc_bout_s = 1'b0;
    sc_ovf_s  = 1'b0;
    sc_dz_s   = 1'b0;
    sc_fv_s   = 1'b0;
    case (kind_s)
      K_AND:   sc_res_s = in_a & in_b;
      K_ANDN:  sc_res_s = in_a & ~in_b;
      K_OR:    sc_res_s = in_a | in_b;
      K_ORN:   sc_res_s = in_a | ~in_b;
      K_XOR:   sc_res_s = in_a ^ in_b;
      K_XORN:  sc_res_s = in_a ^ ~in_b;
      K_NOT:   sc_res_s = ~in_a;
      K_ADD: begin
        sc_res_s  = add_u_s[WIDTH-1:0];
        sc_cout_s = add_u_s[WIDTH];
        sc_ovf_s  = top_not_sext(add_x_s);
        sc_fv_s   = 1'b1;
      end
      K_SUB: begin
        // bit WIDTH of the (WIDTH+1)-bit difference is set exactly when a < b + b_in
        sc_res_s  = sub_u_s[WIDTH-1:0];
        sc_bout_s = sub_u_s[WIDTH];
        sc_ovf_s  = top_not_sext(sub_x_s);
        sc_fv_s   = 1'b1;
      end
      // only reached here with a zero divisor
      K_DIV, K_MOD: begin
        sc_res_s = '0;
        sc_dz_s  = 1'b1;
        sc_fv_s  = 1'b1;
      end
      K_GT:    sc_res_s = {WIDTH{$signed(in_a) >  $signed(in_b)}};
      K_GE:    sc_res_s = {WIDTH{$signed(in_a) >= $signed(in_b)}};
      K_EQ:    sc_res_s = {WIDTH{in_a == in_b}};
      K_NE:    sc_res_s = {WIDTH{in_a != in_b}};
      K_LE:    sc_res_s = {WIDTH{$signed(in_a) <= $signed(in_b)}};
      K_LT:    sc_res_s = {WIDTH{$signed(in_a) <  $signed(in_b)}};
      K_SET:   sc_res_s = ONES_V;
      K_RST:   sc_res_s = '0;
      K_PASSN: sc_res_s = ~in_a;
      default: sc_res_s = in_a;
    endcase
  end

  // One multiply step and one restoring-divide step per ITER cycle.
  always_comb begin
    addend_s  = mplier_q[0] ? mcand_q : '0;
    // the multiplier MSB carries negative weight in two's complement
    acc_nx_s  = last_s ? (acc_q - addend_s) : (acc_q + addend_s);
    rem_sh_s  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    div_ge_s  = (rem_sh_s >= {1'b0, dvsr_q});
    rem_nx_s  = div_ge_s ? (rem_sh_s - {1'b0, dvsr_q}) : rem_sh_s;
    quot_nx_s = {quot_q[WIDTH-2:0], div_ge_s};
    quo_fin_s = neg_quo_q ? neg(quot_nx_s) : quot_nx_s;
    rem_fin_s = neg_rem_q ? neg(rem_nx_s[WIDTH-1:0]) : rem_nx_s[WIDTH-1:0];
  end

  // Final result selection for the last iteration.
  always_comb begin
    fin_res_s = acc_nx_s[WIDTH-1:0];
    fin_ovf_s = 1'b0;
    case (kind_q)
      K_MUL: begin
        fin_res_s = acc_nx_s[WIDTH-1:0];
        fin_ovf_s = (|acc_nx_s[W2-1:WIDTH-1]) & ~(&acc_nx_s[W2-1:WIDTH-1]);
      end
      K_DIV: begin
        // MIN / -1: magnitude quotient is 2^(WIDTH-1), which already reads as MIN
        fin_res_s = quo_fin_s;
        fin_ovf_s = (a_q == MIN_V) & (b_q == ONES_V);
      end
      K_MOD: begin
        fin_res_s = rem_fin_s;
        fin_ovf_s = 1'b0;
      end
      default: begin
        fin_res_s = acc_nx_s[WIDTH-1:0];
        fin_ovf_s = 1'b0;
      end
    endcase
  end

  // Operand latch, iteration state and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q       <= K_AND;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      result_q     <= '0;
      c_out_q      <= 1'b0;
      b_out_q      <= 1'b0;
      ovf_q        <= 1'b0;
      div_zero_q   <= 1'b0;
      flag_valid_q <= 1'b0;
    end else if (accept_s) begin
      kind_q    <= kind_s;
      a_q       <= in_a;
      b_q       <= in_b;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= {{WIDTH{in_a[WIDTH-1]}}, in_a};
      mplier_q  <= in_b;
      rem_q     <= '0;
      quot_q    <= mag(in_a);
      dvsr_q    <= mag(in_b);
      neg_quo_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      neg_rem_q <= in_a[WIDTH-1];
      if (!iter_start_s) begin
        result_q     <= sc_res_s;
        c_out_q      <= sc_cout_s;
        b_out_q      <= sc_bout_s;
        ovf_q        <= sc_ovf_s;
        div_zero_q   <= sc_dz_s;
        flag_valid_q <= sc_fv_s;
      end
    end else if (state_q == S_ITER) begin
      cnt_q    <= cnt_q + CW'(1);
      acc_q    <= acc_nx_s;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_nx_s;
      quot_q   <= quot_nx_s;
      if (last_s) begin
        result_q     <= fin_res_s;
        c_out_q      <= 1'b0;
        b_out_q      <= 1'b0;
        ovf_q        <= fin_ovf_s;
        div_zero_q   <= 1'b0;
        flag_valid_q <= 1'b1;
      end
    end
  end

  assign ready      = ready_s;
  assign done       = done_s;
  assign result     = result_q;
  assign c_out      = c_out_q;
  assign b_out      = b_out_q;
  assign ovf        = ovf_q;
  assign div_zero   = div_zero_q;
  assign flag_valid = flag_valid_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the combinational ALU for the instruction-list core. It accepts one operation per `start` handshake and returns registered results with a one-cycle `done` pulse. Logic, compare and add/sub operations complete in one cycle. MUL, DIV and MOD run iteratively over `WIDTH` cycles. The block sits between the operand-select stage and the accumulator/flag write-back.

## Interface
- `WIDTH`, 8: operand and result width in bits (≥4).
- `IWIDTH`, 8: opcode width.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only when `ready`=1.
- `op_code` input IWIDTH: operation, latched on accept.
- `in_a` input WIDTH: signed operand A, latched on accept.
- `in_b` input WIDTH: signed operand B, latched on accept.
- `c_in` input 1: carry-in for ADD, latched on accept.
- `b_in` input 1: borrow-in for SUB, latched on accept.
- `ready` output 1: block can accept `start`.
- `done` output 1: one-cycle pulse; result and flags are valid.
- `result` output WIDTH: signed result. Holds until the next `done`.
- `c_out` output 1: carry out (ADD only, else 0).
- `b_out` output 1: borrow out (SUB only, else 0).
- `ovf` output 1: signed overflow (ADD/SUB/MUL/DIV).
- `div_zero` output 1: divisor was zero (DIV/MOD).
- `flag_valid` output 1: high with `done` for ADD/SUB/MUL/DIV/MOD.

## Operation
- Opcodes:
  - 0x00 AND, 0x01 ANDN, 0x02 OR, 0x03 ORN, 0x04 XOR, 0x05 XORN.
  - 0x06 NOT: bitwise `~a`.
  - 0x07 ADD, 0x08 SUB, 0x09 MUL, 0x0A DIV, 0x0B MOD.
  - 0x0C GT, 0x0D GE, 0x0E EQ, 0x0F NE, 0x10 LE, 0x11 LT: signed compare; result is all-ones if true, else 0.
  - 0x1B S: all-ones. 0x1C R: 0.
  - 0x1D ST / 0x1F LD: `a`. 0x1E STN / 0x20 LDN: `~a`.
  - Any other opcode: `a`, no flags.
- ADD: `{c_out,result} = a + b + c_in`, computed at WIDTH+1 bits, unsigned. `ovf` = signed overflow (operand signs equal and result sign differs).
- SUB: `result = a - b - b_in`. `b_out`=1 when unsigned `a < b + b_in`. `ovf` = signed overflow.
- MUL: signed shift-add over 2·WIDTH bits. `result` = low WIDTH bits. `ovf`=1 if the product is outside the signed WIDTH range.
- DIV/MOD: signed restoring division on magnitudes, `WIDTH` iterations.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / −1: `result` = most-negative value, `ovf`=1 (DIV only; MOD gives 0).
- Divide by zero, DIV or MOD: no iteration. `result`=0, `div_zero`=1, completes as a single-cycle op.
- Flags not listed for an opcode are driven 0 in its `done` cycle.
- FSM has three states:
  - IDLE, `ready`=1. Accepted single-cycle op → DONE. Accepted MUL/DIV/MOD with nonzero divisor → ITER, iteration counter = 0.
  - ITER, `ready`=0. One iteration per cycle. After iteration WIDTH−1 → DONE.
  - DONE: `done`=1 and `ready`=1 for one cycle. A `start` here is accepted exactly as in IDLE. Otherwise → IDLE.

## Timing
- Reset: state=IDLE, `ready`=1. `done`, `result`, `c_out`, `b_out`, `ovf`, `div_zero`, `flag_valid` = 0. Counter = 0.
- Single-cycle op: start accepted at edge N → `done` high in cycle N+1.
- MUL/DIV/MOD: start accepted at edge N → `ready` low cycles N+1..N+WIDTH → `done` in cycle N+WIDTH+1.
- `start` while `ready`=0 is ignored: no queuing, no effect on the operation in flight.
- Operand inputs may change freely after the accept edge.
- `rst` mid-ITER aborts the operation: no `done`, outputs return to reset values the next cycle.
- `rst` and `start` in the same cycle: reset wins and the request is dropped.
- Back-to-back ops: a start in the DONE cycle gives `done` pulses without a gap cycle for single-cycle ops.

## Test plan
All scenarios use WIDTH=8.
- ADD a=0x7F, b=0x01, c_in=0 → `result`=0x80, `ovf`=1, `c_out`=0, `done` 1 cycle after accept. ADD 0xFF+0x01 → 0x00, `c_out`=1, `ovf`=0.
- SUB a=0x00, b=0x01, b_in=1 → `result`=0xFE, `b_out`=1, `ovf`=0. GT a=0xFF(−1), b=0x01 → `result`=0x00.
- MUL −7×9 → `result`=0xC1, `ovf`=0, `done` exactly 9 cycles after accept, `ready`=0 for 8 cycles. MUL 16×16 → 0x00, `ovf`=1.
- DIV −7/2 → 0xFD. MOD −7/2 → 0xFF. DIV 0x80/0xFF → 0x80, `ovf`=1. DIV 5/0 → `result`=0, `div_zero`=1, `done` after 1 cycle.
- Hold `start`=1 continuously with MUL then AND: the second op is accepted only in the DONE cycle. Operand changes during ITER do not alter the result.
- Assert `rst` in cycle 4 of a MUL → no `done`, all outputs 0 and `ready`=1 the following cycle. A subsequent ADD 3+4 → 0x07.
